phys_reg_file: RTL and testbench
================================

// Module: phys_reg_file
// PURPOSE
//  Physical register file (PRF) for the out-of-order core: NUM_PREGS entries, NUM_RD read ports, NUM_WR writeback ports.
//  Holds a per-entry ready bit (scoreboard): rename allocation clears it, writeback sets it.
//  Feeds issue/operand-read with data plus ready. Write-to-read bypass; optional registered read stage.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  NUM_PREGS   64  physical registers; power of 2, >=2
//  NUM_RD      4   read ports
//  NUM_WR      2   writeback ports
//  NUM_ALLOC   2   rename allocation ports (clear ready)
//  REG_READ    0   0: combinational read; 1: read data/ready registered, 1-cycle latency
//  HAS_P0      1   1: preg 0 hardwired to zero and always ready
//  (derived) PREG_W = $clog2(NUM_PREGS)
// PORTS
//  clk         in   1                     clock, all state updates on posedge
//  rst_n       in   1                     asynchronous, active-low reset
//  rd_addr     in   [NUM_RD][PREG_W]      read addresses
//  rd_data     out  [NUM_RD][DATA_WIDTH]  read data
//  rd_ready    out  [NUM_RD]              ready bit of addressed preg
//  wr_en       in   [NUM_WR]              writeback valid
//  wr_addr     in   [NUM_WR][PREG_W]      writeback destination
//  wr_data     in   [NUM_WR][DATA_WIDTH]  writeback data
//  alloc_en    in   [NUM_ALLOC]           rename allocates new producer
//  alloc_addr  in   [NUM_ALLOC][PREG_W]   allocated preg
//  err_wr_coll out  1                     sticky: >=2 write ports hit same preg in one cycle
// BEHAVIOUR
//  Reset (async): all regs = 0, all ready = 1, err_wr_coll = 0; REG_READ=1: rd_data = 0, rd_ready = 0.
//  Write: at posedge, per enabled port, regs[wr_addr] <= wr_data, ready[wr_addr] <= 1.
//   Ignored when HAS_P0 && wr_addr == 0.
//  Write collision: several enabled ports, same addr -> highest port index wins;
//   err_wr_coll set on that edge, stays set until reset.
//  Alloc: at posedge, ready[alloc_addr] <= 0; ignored for preg 0 when HAS_P0.
//  Alloc and write to same preg, same edge: data written, ready ends 0 (alloc wins).
//  Read, REG_READ=0 (combinational):
//   - HAS_P0 && addr == 0 -> data 0, ready 1.
//   - Else if an enabled write hits addr this cycle -> data = wr_data of winning port, ready 1 (bypass).
//   - Else regs/ready of addr.
//   - Same-cycle alloc does not affect same-cycle read.
//  Read, REG_READ=1: at posedge, rd_data/rd_ready <= the state after that edge's writes and allocs
//   (alloc wins over write) for the addr presented before the edge. Latency exactly 1 cycle, no stall.
//  All ports independent; any number of reads to one addr allowed.
//  Reset mid-operation discards in-flight writes/allocs; no partial update.
// TESTING
//  1 Reset, read p5 on all ports -> data 0, ready 1; err_wr_coll 0.
//  2 Alloc p7; next cycle read p7 -> ready 0.
//    wr p7=0xDEADBEEF -> same-cycle read (REG_READ=0) data 0xDEADBEEF, ready 1; next cycle same from array.
//  3 wr p0=0x1234 -> read p0 = 0, ready 1; HAS_P0=0 build: read p0 = 0x1234.
//  4 Port0 wr p9=0x11, port1 wr p9=0x22, same cycle -> p9 reads 0x22; err_wr_coll = 1 and stays 1.
//  5 Alloc p3 + wr p3=0x55 same edge -> p3 data 0x55, ready 0.
//  6 REG_READ=1: addr p4 with wr p4=0xAA at edge N -> rd_data 0xAA, rd_ready 1 after edge N;
//    rst_n low mid-stream -> rd_data 0, rd_ready 0 immediately.

Source files
------------

// File: rtl/phys_reg_file.sv
// Physical register file with per-entry ready scoreboard, write-to-read bypass
// and an optional registered read stage.
module phys_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PREGS  = 64,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned NUM_ALLOC  = 2,
  parameter int unsigned REG_READ   = 0,
  parameter int unsigned HAS_P0     = 1,
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_RD-1:0][PREG_W-1:0]       rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]                   rd_ready,
  input  logic [NUM_WR-1:0]                   wr_en,
  input  logic [NUM_WR-1:0][PREG_W-1:0]       wr_addr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_ALLOC-1:0]                alloc_en,
  input  logic [NUM_ALLOC-1:0][PREG_W-1:0]    alloc_addr,
  output logic                                err_wr_coll
);

  logic [DATA_WIDTH-1:0] regs [NUM_PREGS];
  logic [NUM_PREGS-1:0]  ready;

  logic [NUM_WR-1:0]                 wr_ok_c;
  logic [NUM_ALLOC-1:0]              alloc_ok_c;
  logic                              coll_c;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] read_data_c;
  logic [NUM_RD-1:0]                 read_ready_c;
  logic [NUM_RD-1:0]                 byp_hit_c;
  logic [NUM_RD-1:0]                 zero_c;

  // Qualify writes/allocs: the hardwired zero register is never touched.
  always_comb begin
    wr_ok_c    = '0;
    alloc_ok_c = '0;
    for (int unsigned w = 0; w < NUM_WR; w++)
      wr_ok_c[w] = wr_en[w] && !((HAS_P0 != 0) && (wr_addr[w] == '0));
    for (int unsigned a = 0; a < NUM_ALLOC; a++)
      alloc_ok_c[a] = alloc_en[a] && !((HAS_P0 != 0) && (alloc_addr[a] == '0));
  end

  // Any two enabled write ports targeting the same preg.
  always_comb begin
    coll_c = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++)
      for (int unsigned j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && (wr_addr[i] == wr_addr[j]))
          coll_c = 1'b1;
  end

  // Array and scoreboard; later ports overwrite earlier ones, allocs override writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++)
        regs[i] <= '0;
      ready       <= '1;
      err_wr_coll <= 1'b0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok_c[w]) begin
          regs[wr_addr[w]]  <= wr_data[w];
          ready[wr_addr[w]] <= 1'b1;
        end
      end
      for (int unsigned a = 0; a < NUM_ALLOC; a++)
        if (alloc_ok_c[a])
          ready[alloc_addr[a]] <= 1'b0;
      if (coll_c)
        err_wr_coll <= 1'b1;
    end
  end

  // Read with bypass from the highest-index writing port.
  always_comb begin
    read_data_c  = '0;
    read_ready_c = '0;
    byp_hit_c    = '0;
    zero_c       = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      zero_c[r]       = (HAS_P0 != 0) && (rd_addr[r] == '0);
      read_data_c[r]  = regs[rd_addr[r]];
      read_ready_c[r] = ready[rd_addr[r]];
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok_c[w] && (wr_addr[w] == rd_addr[r])) begin
          byp_hit_c[r]    = 1'b1;
          read_data_c[r]  = wr_data[w];
          read_ready_c[r] = 1'b1;
        end
      end
      if (zero_c[r]) begin
        read_data_c[r]  = '0;
        read_ready_c[r] = 1'b1;
      end
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [NUM_RD-1:0] post_ready_c;

    // Ready as it will stand after this edge: a same-edge alloc wins.
    always_comb begin
      post_ready_c = read_ready_c;
      for (int unsigned r = 0; r < NUM_RD; r++)
        for (int unsigned a = 0; a < NUM_ALLOC; a++)
          if (alloc_ok_c[a] && (alloc_addr[a] == rd_addr[r]))
            post_ready_c[r] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_ready <= '0;
      end else begin
        rd_data  <= read_data_c;
        rd_ready <= post_ready_c;
      end
    end
  end else begin : g_comb_read
    always_comb begin
      rd_data  = read_data_c;
      rd_ready = read_ready_c;
    end
  end

endmodule

// File: tb/tb_phys_reg_file.sv
// Self-checking bench for phys_reg_file: three configurations share one stimulus
// stream and are compared against a simple array-based reference model.
module tb_phys_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned NP = 64;
  localparam int unsigned NR = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned NA = 2;
  localparam int unsigned PW = 6;

  logic clk;
  logic rst_n;
  logic [NR-1:0][PW-1:0] rd_addr;
  logic [NW-1:0]         wr_en;
  logic [NW-1:0][PW-1:0] wr_addr;
  logic [NW-1:0][DW-1:0] wr_data;
  logic [NA-1:0]         alloc_en;
  logic [NA-1:0][PW-1:0] alloc_addr;

  logic [NR-1:0][DW-1:0] rd_data_a, rd_data_b, rd_data_r;
  logic [NR-1:0]         rd_ready_a, rd_ready_b, rd_ready_r;
  logic                  err_a, err_b, err_r;

  int checks = 0;
  int errors = 0;

  // Reference state: "a" has a hardwired p0, "b" does not.
  logic [DW-1:0] mem_a [NP];
  logic [DW-1:0] mem_b [NP];
  logic          rdy_a [NP];
  logic          rdy_b [NP];
  logic          err_m;
  logic [DW-1:0] rr_d [NR];
  logic          rr_r [NR];

  phys_reg_file #(.REG_READ(0), .HAS_P0(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .err_wr_coll(err_a));

  phys_reg_file #(.REG_READ(0), .HAS_P0(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .err_wr_coll(err_b));

  phys_reg_file #(.REG_READ(1), .HAS_P0(1)) u_r (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_r), .rd_ready(rd_ready_r),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .err_wr_coll(err_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; rdy_a[i] = 1'b1; rdy_b[i] = 1'b1;
    end
    for (int p = 0; p < NR; p++) begin
      rr_d[p] = '0; rr_r[p] = 1'b0;
    end
    err_m = 1'b0;
  endtask

  // One clock edge worth of architectural effect.
  task automatic model_update();
    for (int i = 0; i < NW; i++)
      for (int j = i + 1; j < NW; j++)
        if (wr_en[i] && wr_en[j] && wr_addr[i] == wr_addr[j]) err_m = 1'b1;
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w]) begin
        mem_b[wr_addr[w]] = wr_data[w];
        rdy_b[wr_addr[w]] = 1'b1;
        if (wr_addr[w] != 0) begin
          mem_a[wr_addr[w]] = wr_data[w];
          rdy_a[wr_addr[w]] = 1'b1;
        end
      end
    end
    for (int a = 0; a < NA; a++) begin
      if (alloc_en[a]) begin
        rdy_b[alloc_addr[a]] = 1'b0;
        if (alloc_addr[a] != 0) rdy_a[alloc_addr[a]] = 1'b0;
      end
    end
  endtask

  function automatic void exp_read(input bit p0, input logic [PW-1:0] addr,
                                   output logic [DW-1:0] d, output logic r);
    d = p0 ? mem_a[addr] : mem_b[addr];
    r = p0 ? rdy_a[addr] : rdy_b[addr];
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && wr_addr[w] == addr) begin d = wr_data[w]; r = 1'b1; end
    if (p0 && addr == 0) begin d = '0; r = 1'b1; end
  endfunction

  // Advance one edge; the registered-read expectation is the post-edge state at the pre-edge address.
  task automatic tick();
    logic [NR-1:0][PW-1:0] pa;
    pa = rd_addr;
    @(posedge clk);
    model_update();
    for (int p = 0; p < NR; p++) begin
      rr_d[p] = mem_a[pa[p]];
      rr_r[p] = rdy_a[pa[p]];
    end
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = '0; alloc_addr = '0;
  endtask

  task automatic all_rd(input logic [PW-1:0] addr);
    for (int p = 0; p < NR; p++) rd_addr[p] = addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    all_rd(6'd5);
    model_reset();
    #12;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_data_r[p] !== '0 || rd_ready_r[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rr p%0d: got %h/%b exp 0/0", p, rd_data_r[p], rd_ready_r[p]);
      end
    end
    rst_n = 1'b1;
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_data_a[p] !== '0 || rd_ready_a[p] !== 1'b1 || rd_data_b[p] !== '0 || rd_ready_b[p] !== 1'b1) begin
        errors++;
        $display("FAIL reset_read p%0d: got a %h/%b b %h/%b exp 0/1", p,
                 rd_data_a[p], rd_ready_a[p], rd_data_b[p], rd_ready_b[p]);
      end
    end
    checks++;
    if ({err_a, err_b, err_r} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err: got %b%b%b exp 000", err_a, err_b, err_r);
    end
    tick();
    checks++;
    if (rd_data_r[0] !== '0 || rd_ready_r[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_rr_after_edge: got %h/%b exp 0/1", rd_data_r[0], rd_ready_r[0]);
    end
  endtask

  task automatic test_alloc_write();
    idle();
    all_rd(6'd7);
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd7;
    #1;
    checks++;
    if (rd_ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL alloc_same_cycle: got ready %b exp 1", rd_ready_a[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_ready_a[1] !== 1'b0 || rd_ready_b[1] !== 1'b0 || rd_ready_r[1] !== 1'b0) begin
      errors++;
      $display("FAIL alloc_ready: got a %b b %b r %b exp 0", rd_ready_a[1], rd_ready_b[1], rd_ready_r[1]);
    end
    wr_en[0] = 1'b1; wr_addr[0] = 6'd7; wr_data[0] = 32'hDEADBEEF;
    #1;
    checks++;
    if (rd_data_a[2] !== 32'hDEADBEEF || rd_ready_a[2] !== 1'b1) begin
      errors++;
      $display("FAIL bypass: got %h/%b exp deadbeef/1", rd_data_a[2], rd_ready_a[2]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_a[3] !== 32'hDEADBEEF || rd_ready_a[3] !== 1'b1 ||
        rd_data_r[3] !== 32'hDEADBEEF || rd_ready_r[3] !== 1'b1) begin
      errors++;
      $display("FAIL array_read: got a %h/%b r %h/%b exp deadbeef/1",
               rd_data_a[3], rd_ready_a[3], rd_data_r[3], rd_ready_r[3]);
    end
  endtask

  task automatic test_p0();
    idle();
    all_rd(6'd0);
    wr_en[0] = 1'b1; wr_addr[0] = 6'd0; wr_data[0] = 32'h1234;
    #1;
    checks++;
    if (rd_data_a[0] !== '0 || rd_ready_a[0] !== 1'b1 || rd_data_b[0] !== 32'h1234) begin
      errors++;
      $display("FAIL p0_bypass: got a %h/%b b %h exp a 0/1 b 1234", rd_data_a[0], rd_ready_a[0], rd_data_b[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_a[1] !== '0 || rd_ready_a[1] !== 1'b1 || rd_data_b[1] !== 32'h1234 ||
        rd_data_r[1] !== '0 || rd_ready_r[1] !== 1'b1) begin
      errors++;
      $display("FAIL p0_array: got a %h/%b b %h r %h/%b exp a 0/1 b 1234 r 0/1",
               rd_data_a[1], rd_ready_a[1], rd_data_b[1], rd_data_r[1], rd_ready_r[1]);
    end
  endtask

  task automatic test_collision();
    idle();
    all_rd(6'd9);
    wr_en = 2'b11; wr_addr[0] = 6'd9; wr_addr[1] = 6'd9;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22;
    #1;
    checks++;
    if (rd_data_a[0] !== 32'h22 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL coll_bypass: got %h err %b exp 22 err 0", rd_data_a[0], err_a);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_a[1] !== 32'h22 || rd_data_b[1] !== 32'h22 || rd_data_r[1] !== 32'h22) begin
      errors++;
      $display("FAIL coll_data: got a %h b %h r %h exp 22", rd_data_a[1], rd_data_b[1], rd_data_r[1]);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({err_a, err_b, err_r} !== 3'b111) begin
        errors++;
        $display("FAIL coll_sticky c%0d: got %b%b%b exp 111", c, err_a, err_b, err_r);
      end
      tick();
    end
  endtask

  task automatic test_alloc_write_same();
    idle();
    all_rd(6'd3);
    alloc_en[1] = 1'b1; alloc_addr[1] = 6'd3;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd3; wr_data[0] = 32'h55;
    #1;
    checks++;
    if (rd_data_a[0] !== 32'h55 || rd_ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL aw_bypass: got %h/%b exp 55/1", rd_data_a[0], rd_ready_a[0]);
    end
    tick();
    checks++;
    if (rd_data_r[0] !== 32'h55 || rd_ready_r[0] !== 1'b0) begin
      errors++;
      $display("FAIL aw_rr: got %h/%b exp 55/0", rd_data_r[0], rd_ready_r[0]);
    end
    idle();
    #1;
    checks++;
    if (rd_data_a[2] !== 32'h55 || rd_ready_a[2] !== 1'b0 || rd_data_b[2] !== 32'h55 || rd_ready_b[2] !== 1'b0) begin
      errors++;
      $display("FAIL aw_array: got a %h/%b b %h/%b exp 55/0", rd_data_a[2], rd_ready_a[2], rd_data_b[2], rd_ready_b[2]);
    end
  endtask

  task automatic test_reg_read_reset();
    idle();
    all_rd(6'd4);
    wr_en[1] = 1'b1; wr_addr[1] = 6'd4; wr_data[1] = 32'hAA;
    tick();
    checks++;
    if (rd_data_r[0] !== 32'hAA || rd_ready_r[0] !== 1'b1) begin
      errors++;
      $display("FAIL rr_latency: got %h/%b exp aa/1", rd_data_r[0], rd_ready_r[0]);
    end
    wr_data[1] = 32'hBB;
    #1;
    rst_n = 1'b0;
    model_reset();
    idle();
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_data_r[p] !== '0 || rd_ready_r[p] !== 1'b0 || rd_data_a[p] !== '0 || rd_ready_a[p] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset p%0d: got r %h/%b a %h/%b exp r 0/0 a 0/1",
                 p, rd_data_r[p], rd_ready_r[p], rd_data_a[p], rd_ready_a[p]);
      end
    end
    checks++;
    if ({err_a, err_b, err_r} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_err: got %b%b%b exp 000", err_a, err_b, err_r);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rd_data_r[0] !== '0 || rd_ready_r[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: got %h/%b exp 0/1", rd_data_r[0], rd_ready_r[0]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic          r;
    for (int it = 0; it < 400; it++) begin
      for (int w = 0; w < NW; w++) begin
        wr_en[w]   = ($urandom_range(0, 1) == 1);
        wr_addr[w] = PW'($urandom_range(0, 15));
        wr_data[w] = $urandom;
      end
      if (wr_en == 2'b11 && wr_addr[0] == 0 && wr_addr[1] == 0) wr_en[1] = 1'b0;
      for (int a = 0; a < NA; a++) begin
        alloc_en[a]   = ($urandom_range(0, 2) == 0);
        alloc_addr[a] = PW'($urandom_range(0, 15));
      end
      for (int p = 0; p < NR; p++)
        rd_addr[p] = ($urandom_range(0, 3) == 0) ? wr_addr[$urandom_range(0, NW - 1)]
                                                 : PW'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < NR; p++) begin
        exp_read(1'b1, rd_addr[p], d, r);
        checks++;
        if (rd_data_a[p] !== d || rd_ready_a[p] !== r) begin
          errors++;
          $display("FAIL rand_a it%0d p%0d addr %0d: got %h/%b exp %h/%b", it, p, rd_addr[p], rd_data_a[p], rd_ready_a[p], d, r);
        end
        exp_read(1'b0, rd_addr[p], d, r);
        checks++;
        if (rd_data_b[p] !== d || rd_ready_b[p] !== r) begin
          errors++;
          $display("FAIL rand_b it%0d p%0d addr %0d: got %h/%b exp %h/%b", it, p, rd_addr[p], rd_data_b[p], rd_ready_b[p], d, r);
        end
      end
      tick();
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rd_data_r[p] !== rr_d[p] || rd_ready_r[p] !== rr_r[p]) begin
          errors++;
          $display("FAIL rand_rr it%0d p%0d: got %h/%b exp %h/%b", it, p, rd_data_r[p], rd_ready_r[p], rr_d[p], rr_r[p]);
        end
      end
      checks++;
      if (err_a !== err_m || err_b !== err_m || err_r !== err_m) begin
        errors++;
        $display("FAIL rand_err it%0d: got %b%b%b exp %b", it, err_a, err_b, err_r, err_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc_write();
    test_p0();
    test_collision();
    test_alloc_write_same();
    test_reg_read_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
